// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: turns a byte stream into FIPS 180-4 padded 512-bit blocks
// (0x80 marker, zero fill, 64-bit big-endian bit length). Byte 0 of a block is
// blk_data[511:504], so the block can feed the SHA256 message schedule directly.
//
// Handshake: on both sides a transfer happens on a rising clock edge where
// valid && ready are both high. in_ready depends only on the FSM state. blk_data,
// blk_first and blk_last are held stable while blk_valid && !blk_ready.
// blk_valid never drops without a transfer.
module sha256_msg_padder #(
  parameter int BLK_W = 512,
  parameter int LEN_W = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [BLK_W-1:0] blk_data,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic             blk_first,
  output logic             blk_last,
  output logic             busy
);

  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_PAD  = 2'd1;
  localparam logic [1:0] S_LEN  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  generate
    if (BLK_W != 512) begin : g_bad_blk_w
      $error("sha256_msg_padder: BLK_W must be 512");
    end
    if (LEN_W < 4 || LEN_W > 64) begin : g_bad_len_w
      $error("sha256_msg_padder: LEN_W must be in 4..64");
    end
  endgenerate

  logic [1:0]       state;       // FSM state, visible for checkers
  logic [6:0]       ptr;         // next byte slot in the block, 0..64
  logic [LEN_W-1:0] bitlen;      // message length in bits so far
  logic [BLK_W-1:0] buffer;      // block under construction / being offered
  logic             marker_done; // 0x80 already placed for this message
  logic             first_pend;  // next block offered is the message's first
  logic             last_r;      // block in OUT carries the length field
  logic             pad_pend;    // in_last seen; padding still in progress
  logic [63:0]      len64;

  // Length field is the bit counter zero-extended to 64 bits.
  assign len64    = 64'(bitlen);
  assign blk_data = buffer;
  assign in_ready = (state == S_FILL);
  assign busy     = (state != S_FILL) || (ptr != 7'd0);

  // Main FSM: byte fill, marker/zero padding, length insertion, block handoff.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_FILL;
      ptr         <= 7'd0;
      bitlen      <= '0;
      buffer      <= '0;
      marker_done <= 1'b0;
      first_pend  <= 1'b1;
      last_r      <= 1'b0;
      pad_pend    <= 1'b0;
      blk_valid   <= 1'b0;
      blk_first   <= 1'b0;
      blk_last    <= 1'b0;
    end else begin
      case (state)
        S_FILL: begin
          if (in_valid) begin
            for (int i = 0; i < 64; i++) begin
              if (ptr == 7'(i)) buffer[511-8*i -: 8] <= in_data;
            end
            ptr    <= ptr + 7'd1;
            bitlen <= bitlen + LEN_W'(8);
            if (in_last) begin
              pad_pend <= 1'b1;
              state    <= S_PAD;
            end else if (ptr == 7'd63) begin
              last_r <= 1'b0;
              state  <= S_OUT;
            end
          end
        end
        S_PAD: begin
          if (!marker_done) begin
            if (ptr != 7'd64) begin
              // Marker at ptr, everything after it cleared.
              for (int i = 0; i < 64; i++) begin
                if (ptr == 7'(i))      buffer[511-8*i -: 8] <= 8'h80;
                else if (7'(i) > ptr)  buffer[511-8*i -: 8] <= 8'h00;
              end
              marker_done <= 1'b1;
              if (ptr <= 7'd55) begin
                state <= S_LEN;
              end else begin
                // No room for the length: it goes into an extra block.
                last_r <= 1'b0;
                state  <= S_OUT;
              end
            end else begin
              // Block full exactly at the last byte: marker starts the next block.
              last_r <= 1'b0;
              state  <= S_OUT;
            end
          end else begin
            state <= S_LEN;
          end
        end
        S_LEN: begin
          buffer[63:0] <= len64;
          last_r       <= 1'b1;
          state        <= S_OUT;
        end
        S_OUT: begin
          if (!blk_valid) begin
            blk_valid <= 1'b1;
            blk_first <= first_pend;
            blk_last  <= last_r;
          end else if (blk_ready) begin
            blk_valid  <= 1'b0;
            blk_first  <= 1'b0;
            blk_last   <= 1'b0;
            buffer     <= '0;
            ptr        <= 7'd0;
            first_pend <= 1'b0;
            if (last_r) begin
              state       <= S_FILL;
              bitlen      <= '0;
              marker_done <= 1'b0;
              first_pend  <= 1'b1;
              pad_pend    <= 1'b0;
              last_r      <= 1'b0;
            end else if (pad_pend) begin
              state <= S_PAD;
            end else begin
              state <= S_FILL;
            end
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: directed vectors for the SHA256 message padder.
module tb_sha256_msg_padder;

  logic         clock = 1'b0;
  logic         reset;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [511:0] blk_data;
  logic         blk_valid;
  logic         blk_ready;
  logic         blk_first;
  logic         blk_last;
  logic         busy;

  int total = 0;
  int bad   = 0;

  logic [511:0] exp_q[$];
  logic [1:0]   exp_flags_q[$];   // {first, last}

  // Message description plus hand-computed padding position and length field.
  typedef struct {
    int          len;
    int          base;
    int          step;
    int          nblk;
    int          mblk;
    int          mbyte;
    logic [63:0] lenf;
  } vec_t;

  vec_t vecs[6];

  sha256_msg_padder #(.BLK_W(512), .LEN_W(64)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_first (blk_first),
    .blk_last  (blk_last),
    .busy      (busy)
  );

  // Clock
  always #5 clock = ~clock;

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  task automatic check_blk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Build expected blocks from the message bytes and the hand-given padding facts.
  task automatic enqueue_msg(input vec_t v);
    logic [511:0] blk;
    logic [7:0]   val;
    int           idx;
    for (int b = 0; b < v.nblk; b++) begin
      blk = '0;
      for (int i = 0; i < 64; i++) begin
        idx = b * 64 + i;
        if (idx < v.len)                        val = 8'(v.base + v.step * idx);
        else if (b == v.mblk && i == v.mbyte)   val = 8'h80;
        else                                    val = 8'h00;
        blk[511-8*i -: 8] = val;
      end
      if (b == v.nblk - 1) blk[63:0] = v.lenf;
      exp_q.push_back(blk);
      exp_flags_q.push_back({b == 0, b == v.nblk - 1});
    end
  endtask

  // Driver: present one byte until accepted (bounded).
  task automatic send_byte(input logic [7:0] d, input logic l);
    logic acc;
    acc      = 1'b0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    for (int n = 0; n < 500 && !acc; n++) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 want byte %h accepted", d);
    end
  endtask

  task automatic send_msg(input vec_t v);
    for (int i = 0; i < v.len; i++) send_byte(8'(v.base + v.step * i), i == v.len - 1);
  endtask

  task automatic wait_drain(input string name);
    logic done;
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(posedge clock);
      #1;
      done = (exp_q.size() == 0) && !busy && !blk_valid;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s: got %0d blocks outstanding busy=%0b want 0 idle", name, exp_q.size(), busy);
    end
  endtask

  // Scoreboard: compare every block handed off against the expected queue.
  logic [511:0] mon_e;
  logic [1:0]   mon_f;
  always @(negedge clock) begin
    if (!reset && blk_valid && blk_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_block: got %h want none", blk_data);
      end else begin
        mon_e = exp_q.pop_front();
        mon_f = exp_flags_q.pop_front();
        check_blk("blk_data", blk_data, mon_e);
        check_bit("blk_first", blk_first, mon_f[1]);
        check_bit("blk_last", blk_last, mon_f[0]);
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  localparam logic [511:0] ABC_BLK = {32'h61626380, 416'h0, 64'h18};

  initial begin : main
    logic [511:0] exp0;
    int           lat;
    logic         seen;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    blk_ready = 1'b1;

    //            len  base  step nblk mblk mbyte lenf
    vecs[0] = '{  3,   'h61, 1,   1,   0,   3,    64'h18 };
    vecs[1] = '{  55,  0,    0,   1,   0,   55,   64'h1B8 };
    vecs[2] = '{  56,  0,    0,   2,   0,   56,   64'h1C0 };
    vecs[3] = '{  64,  0,    1,   2,   1,   0,    64'h200 };
    vecs[4] = '{  120, 'h30, 3,   3,   1,   56,   64'h3C0 };
    vecs[5] = '{  1,   'h7F, 0,   1,   0,   1,    64'h8 };

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_bit("rst_in_ready", in_ready, 1'b1);
    check_bit("rst_blk_valid", blk_valid, 1'b0);
    check_bit("rst_blk_first", blk_first, 1'b0);
    check_bit("rst_blk_last", blk_last, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_bit("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clock);
    #1;

    // Table-driven vectors with blk_ready held high
    for (int k = 0; k < 6; k++) begin
      enqueue_msg(vecs[k]);
      send_msg(vecs[k]);
      wait_drain("drain_vec");
    end

    // "abc" latency and literal block value
    blk_ready = 1'b0;
    enqueue_msg(vecs[0]);
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    send_byte(8'h63, 1'b1);
    lat  = -1;
    seen = 1'b0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(posedge clock);
      #1;
      if (blk_valid) begin
        lat  = n;
        seen = 1'b1;
      end
    end
    check_int("abc_latency", lat, 3);
    check_blk("abc_literal", blk_data, ABC_BLK);
    check_bit("abc_first", blk_first, 1'b1);
    check_bit("abc_last", blk_last, 1'b1);
    blk_ready = 1'b1;
    wait_drain("drain_abc");

    // Backpressure on the 64-byte message, with stray bytes offered during the stall
    blk_ready = 1'b0;
    enqueue_msg(vecs[3]);
    exp0 = exp_q[0];
    send_msg(vecs[3]);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(posedge clock);
      #1;
      seen = blk_valid;
    end
    check_bit("bp_valid_rise", seen, 1'b1);
    in_data  = 8'hEE;
    in_last  = 1'b0;
    in_valid = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clock);
      check_blk("bp_data_stable", blk_data, exp0);
      check_bit("bp_valid_held", blk_valid, 1'b1);
      check_bit("bp_first_held", blk_first, 1'b1);
      check_bit("bp_last_held", blk_last, 1'b0);
      check_bit("bp_in_ready", in_ready, 1'b0);
      @(posedge clock);
      #1;
    end
    in_valid  = 1'b0;
    blk_ready = 1'b1;
    wait_drain("drain_bp");

    // Reset mid-message, then "abc" must come out as a fresh first block
    for (int i = 0; i < 20; i++) send_byte(8'h11, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    check_bit("midrst_in_ready", in_ready, 1'b1);
    check_bit("midrst_busy", busy, 1'b0);
    check_bit("midrst_blk_valid", blk_valid, 1'b0);
    @(posedge clock);
    #1 reset = 1'b0;
    enqueue_msg(vecs[0]);
    send_msg(vecs[0]);
    wait_drain("drain_midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
